// File: rtl/setn_sequencer.sv
// setn_sequencer: active-low set sequencer for a downstream set-flop bank.
// Holds SETN_OUT low through reset release (synchronizer + stretch) and for
// fixed-width software set pulses; reports BUSY, DONE and dropped requests.
module setn_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH     = 4,
  parameter int unsigned PULSE_W     = 3
) (
  input  logic CLK,
  input  logic RN,
  input  logic REQ_SET,
  output logic SETN_OUT,
  output logic BUSY,
  output logic DONE,
  output logic DROP
);

  // The state register leaving RST_SYNC acts as the final synchronizer stage,
  // so only SYNC_STAGES-1 dedicated flops are needed ahead of it.
  localparam int unsigned SYNC_W = SYNC_STAGES - 1;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    RST_SYNC = 2'd0,
    RST_HOLD = 2'd1,
    IDLE     = 2'd2,
    SW_SET   = 2'd3
  } state_t;

  state_t            state;
  logic [SYNC_W-1:0] sync_q;
  logic [CNT_W-1:0]  cnt;

  // RN deassertion synchronizer: shifts ones in once RN is released
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
    end else begin
      sync_q <= SYNC_W'({sync_q, 1'b1});
    end
  end

  // Sequencer FSM with registered SETN_OUT/BUSY/DONE/DROP
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= RST_SYNC;
      cnt      <= '0;
      SETN_OUT <= 1'b0;
      BUSY     <= 1'b1;
      DONE     <= 1'b0;
      DROP     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      DROP <= REQ_SET && (state != IDLE);
      case (state)
        RST_SYNC: begin
          if (sync_q[SYNC_W-1]) begin
            state <= RST_HOLD;
            cnt   <= STRETCH_LOAD;
          end
        end
        RST_HOLD, SW_SET: begin
          if (cnt == '0) begin
            state    <= IDLE;
            SETN_OUT <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        IDLE: begin
          if (REQ_SET) begin
            state    <= SW_SET;
            cnt      <= PULSE_LOAD;
            SETN_OUT <= 1'b0;
            BUSY     <= 1'b1;
          end
        end
        default: begin
          state    <= RST_SYNC;
          cnt      <= '0;
          SETN_OUT <= 1'b0;
          BUSY     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_setn_sequencer.sv
// tb_setn_sequencer: scoreboard bench for setn_sequencer (default and swept parameters).
module tb_setn_sequencer;

  logic clk;
  logic rn, req;
  logic setn_out, busy, done, drop;
  logic rn_p, req_p;
  logic setn_p, busy_p, done_p, drop_p;

  int checks;
  int failures;

  // expected {SETN_OUT, BUSY, DONE, DROP} per cycle
  logic [3:0] sb_q[$];

  setn_sequencer u_dut (
    .CLK(clk), .RN(rn), .REQ_SET(req),
    .SETN_OUT(setn_out), .BUSY(busy), .DONE(done), .DROP(drop)
  );

  setn_sequencer #(.SYNC_STAGES(3), .STRETCH(1), .PULSE_W(1)) u_dut_p (
    .CLK(clk), .RN(rn_p), .REQ_SET(req_p),
    .SETN_OUT(setn_p), .BUSY(busy_p), .DONE(done_p), .DROP(drop_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got, exp;
    logic [3:0] tbl [7];
    tbl = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1010, 4'b1000};
    #1;
    got = {setn_out, busy, done, drop};
    checks++;
    if (got !== 4'b0100) begin
      failures++;
      $display("FAIL reset_async: got %b expected %b", got, 4'b0100);
    end
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(4'b0100);
      step();
      got = {setn_out, busy, done, drop};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_held cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    rn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(tbl[i]);
      step();
      got = {setn_out, busy, done, drop};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL powerup edge %0d: got %b expected %b", i + 1, got, exp);
      end
    end
  endtask

  task automatic test_sw_set();
    logic [3:0] got, exp;
    logic [3:0] tbl [5];
    tbl = '{4'b0100, 4'b0100, 4'b0100, 4'b1010, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      req = (i == 0);
      sb_q.push_back(tbl[i]);
      step();
      got = {setn_out, busy, done, drop};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL sw_set cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_drop();
    logic [3:0] got, exp;
    logic [3:0] tbl [7];
    logic       reqs [7];
    tbl  = '{4'b0100, 4'b0100, 4'b0101, 4'b1010, 4'b1000, 4'b1000, 4'b1000};
    reqs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      req = reqs[i];
      sb_q.push_back(tbl[i]);
      step();
      got = {setn_out, busy, done, drop};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL drop cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_held();
    logic [3:0] got, exp;
    logic [3:0] tbl [13];
    tbl = '{4'b0100, 4'b0101, 4'b0101, 4'b1011, 4'b0100, 4'b0101, 4'b0101,
            4'b1011, 4'b0100, 4'b0101, 4'b0100, 4'b1010, 4'b1000};
    for (int i = 0; i < 13; i++) begin
      req = (i < 10);
      sb_q.push_back(tbl[i]);
      step();
      got = {setn_out, busy, done, drop};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL held cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] got, exp;
    logic [3:0] tbl [7];
    tbl = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1010, 4'b1000};
    for (int i = 0; i < 2; i++) begin
      req = (i == 0);
      sb_q.push_back(4'b0100);
      step();
      got = {setn_out, busy, done, drop};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL mid_sw cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    req = 1'b0;
    // short RN pulse between edges, inside cycle 2 of SW_SET
    #2 rn = 1'b0;
    #1;
    got = {setn_out, busy, done, drop};
    checks++;
    if (got !== 4'b0100) begin
      failures++;
      $display("FAIL mid_async: got %b expected %b", got, 4'b0100);
    end
    #2 rn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      got = {setn_out, busy, done, drop};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL mid_release edge %0d: got %b expected %b", i + 1, got, exp);
      end
    end
  endtask

  task automatic test_param();
    logic [3:0] got, exp;
    logic [3:0] tbl [8];
    tbl = '{4'b0100, 4'b0100, 4'b0100, 4'b1010, 4'b1000,
            4'b0100, 4'b1010, 4'b1000};
    rn_p = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_p = (i == 5);
      sb_q.push_back(tbl[i]);
      step();
      got = {setn_p, busy_p, done_p, drop_p};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL param cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    req_p = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rn    = 1'b1;
    req   = 1'b0;
    rn_p  = 1'b1;
    req_p = 1'b0;
    #1;
    rn   = 1'b0;
    rn_p = 1'b0;
    test_reset();
    test_sw_set();
    test_drop();
    test_held();
    test_reset_mid();
    test_param();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/setn_sequencer.md
SETN_SEQUENCER -- requirements
Module: setn_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops in the RN deassertion synchronizer; legal range 2..4.
REQ-002 Parameter STRETCH, default 4, cycles SETN_OUT stays low after the synchronized RN release; legal range 1..255.
REQ-003 Parameter PULSE_W, default 3, cycles SETN_OUT stays low for a software set request; legal range 1..255.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RN  input  1  asynchronous active-low reset.
REQ-006 REQ_SET  input  1  synchronous software set request, sampled on the rising CLK edge.
REQ-007 SETN_OUT  output  1  registered active-low set that drives the SETN pins of a downstream set-flop bank.
REQ-008 BUSY  output  1  high whenever SETN_OUT is low or a sequence is in progress.
REQ-009 DONE  output  1  one-cycle pulse in the cycle SETN_OUT first reads 1 after any low period.
REQ-010 DROP  output  1  one-cycle pulse when REQ_SET=1 is sampled while not in IDLE.

Function
REQ-011 The block SHALL implement states RST_SYNC, RST_HOLD, IDLE and SW_SET.
REQ-012 SETN_OUT SHALL be driven directly from a flop, with no combinational path from any input other than the asynchronous RN clear.
REQ-013 RST_SYNC SHALL wait until the last synchronizer stage reads 1, then move to RST_HOLD with the counter loaded to STRETCH-1.
REQ-014 RST_HOLD SHALL decrement the counter each cycle and move to IDLE on the edge after the counter reads 0.
REQ-015 SETN_OUT SHALL first read 1 exactly SYNC_STAGES+STRETCH rising edges after RN rises, counting the first edge after the rise as edge 1; with defaults this is edge 6.
REQ-016 In IDLE, REQ_SET=1 at a rising edge SHALL move to SW_SET, drive SETN_OUT=0 from that edge, and load the counter to PULSE_W-1.
REQ-017 SW_SET SHALL hold SETN_OUT=0 for exactly PULSE_W cycles, then return to IDLE with SETN_OUT=1.
REQ-018 DONE SHALL pulse for one cycle on entry to IDLE from RST_HOLD or SW_SET, and SHALL be 0 at all other times.
REQ-019 REQ_SET sampled in RST_SYNC, RST_HOLD or SW_SET SHALL be ignored and not queued, and SHALL pulse DROP in the following cycle.
REQ-020 REQ_SET held high continuously SHALL re-trigger SW_SET on the first edge after each return to IDLE, giving back-to-back PULSE_W-wide lows separated by one high cycle.
REQ-021 BUSY SHALL be 1 in RST_SYNC, RST_HOLD and SW_SET, and 0 only in IDLE.
REQ-022 The counter SHALL be 8 bits wide and SHALL never wrap; legal parameter values guarantee it reaches 0.

Reset
REQ-023 RN=0 SHALL immediately, without a clock edge, force:
- SETN_OUT=0, BUSY=1, DONE=0, DROP=0;
- synchronizer all 0, counter 0, state RST_SYNC.
REQ-024 RN assertion at any point, including mid RST_HOLD or mid SW_SET, SHALL abort the sequence and restart from RST_SYNC with no DONE pulse.
REQ-025 An RN low pulse of any width SHALL produce a full SYNC_STAGES+STRETCH low period on SETN_OUT after RN rises.
REQ-026 RN deassertion SHALL only take effect through the synchronizer, never directly on SETN_OUT or the state.

Verification
REQ-027 Power-up (defaults): RN low 3 cycles, then high -> SETN_OUT=0 through edge 5, reads 1 after edge 6; DONE=1 for that single cycle; BUSY falls with it.
REQ-028 SW set: in IDLE, REQ_SET=1 for one cycle -> SETN_OUT=0 for exactly 3 cycles, then 1; DONE pulses once; BUSY=1 for those 3 cycles.
REQ-029 Drop: REQ_SET=1 two cycles into SW_SET -> DROP=1 one cycle later; SW_SET length unchanged at 3 cycles; no second sequence starts.
REQ-030 Reset mid-sequence: RN low during cycle 2 of SW_SET -> SETN_OUT stays 0 asynchronously; no DONE pulse; after RN rises, release on edge 6.
REQ-031 Held request: REQ_SET held high 10 cycles from IDLE -> pattern of 3 cycles low, 1 high, 3 low, 1 high; DONE pulses at each rise.
REQ-032 Parameter sweep: SYNC_STAGES=3, STRETCH=1, PULSE_W=1 -> SETN_OUT rises on edge 4 after RN rises; a single REQ_SET gives a one-cycle low.
